mdr_seq_mult: RTL and testbench

Sequential signed shift-add multiplier for the MDR datapath. It accepts two DW-bit two's-complement operands on a start pulse and iterates one partial product per clock. After a fixed latency it presents the 2·DW-bit product together with a one-cycle `done` strobe. `done` drives the enable of the downstream double-width result register (the PIPO stage), and `product` drives that register's data input.

---
 rtl/mdr_pkg.sv | 19 +
 rtl/mdr_abs.sv | 16 +
 rtl/mdr_seq_mult.sv | 140 ++++++++++++++
 tb/tb_mdr_seq_mult.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/mdr_pkg.sv
// mdr_pkg -- shared constants and types for the MDR multiply datapath.
//   DW      : operand width in bits
//   DW_DBL  : MSB index of the double-width product (also used by the PIPO stage)
//   CNT_W   : width of the iteration counter, wide enough to count to DW
//   mult_state_e : sequencer states of mdr_seq_mult
package mdr_pkg;

   localparam int DW     = 16;
   localparam int DW_DBL = 2*DW - 1;
   localparam int CNT_W  = $clog2(DW + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } mult_state_e;

endpackage

// File: rtl/mdr_abs.sv
// mdr_abs -- combinational two's-complement magnitude.
//   a   : DW-bit signed input
//   mag : DW-bit unsigned magnitude of a; the most negative value maps to
//         2^(DW-1), which still fits as an unsigned DW-bit number.
module mdr_abs
   import mdr_pkg::*;
(
   input  logic [DW-1:0] a,
   output logic [DW-1:0] mag
);

   always_comb begin
      mag = a[DW-1] ? -a : a;
   end

endmodule

// File: rtl/mdr_seq_mult.sv
// mdr_seq_mult -- sequential signed shift-add multiplier.
// Multiplies operand magnitudes one bit per clock, then applies the sign in
// a separate FIX cycle and strobes done for exactly one cycle.
//   clk      : clock, rising edge
//   rst      : asynchronous, active-low reset
//   sync_clr : synchronous clear, overrides everything
//   start    : request, sampled only in IDLE
//   op_a     : signed multiplicand
//   op_b     : signed multiplier
//   busy     : high from the cycle after acceptance through the done cycle
//   done     : one-cycle strobe, product valid (drives the PIPO enable)
//   product  : signed 2*DW-bit product, held until the next FIX
//
// Handshake: start is a request with no back-pressure. It is accepted only
// while the sequencer is IDLE; requests at any other time (including the
// done cycle) are dropped, not queued. busy rises on the acceptance edge and
// falls on the edge after done. done is high for exactly one cycle and
// product is stable while done is high and afterwards until the next result.
module mdr_seq_mult
   import mdr_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            sync_clr,
   input  logic            start,
   input  logic [DW-1:0]   op_a,
   input  logic [DW-1:0]   op_b,
   output logic            busy,
   output logic            done,
   output logic [DW_DBL:0] product
);

   mult_state_e      state_q, state_d;
   logic [DW-1:0]    mcand_q, mcand_d;   // multiplicand magnitude
   logic [DW-1:0]    mlt_q,   mlt_d;     // multiplier, shifted out LSB first; fills with low product bits
   logic [DW:0]      hi_q,    hi_d;      // upper accumulator bits plus carry
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic             sign_q,  sign_d;
   logic             busy_q,  busy_d;
   logic             done_q,  done_d;
   logic [DW_DBL:0]  product_q, product_d;

   logic [DW-1:0]    abs_a;
   logic [DW-1:0]    abs_b;
   logic [DW:0]      sum;
   logic [DW_DBL+1:0] shifted;
   logic [DW_DBL:0]  mag;

   mdr_abs u_abs_a (.a(op_a), .mag(abs_a));
   mdr_abs u_abs_b (.a(op_b), .mag(abs_b));

   always_comb begin
      state_d   = state_q;
      mcand_d   = mcand_q;
      mlt_d     = mlt_q;
      hi_d      = hi_q;
      cnt_d     = cnt_q;
      sign_d    = sign_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      product_d = product_q;

      // hi_q[DW] is always 0 after a shift, so this sum cannot overflow DW+1 bits.
      sum     = hi_q + {1'b0, (mlt_q[0] ? mcand_q : {DW{1'b0}})};
      shifted = {sum, mlt_q} >> 1;
      // After DW iterations the full magnitude sits in {hi, mlt}.
      mag     = {hi_q[DW-1:0], mlt_q};

      case (state_q)
         IDLE: begin
            if (start) begin
               mcand_d = abs_a;
               mlt_d   = abs_b;
               sign_d  = op_a[DW-1] ^ op_b[DW-1];
               hi_d    = '0;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            {hi_d, mlt_d} = shifted;
            cnt_d         = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(DW - 1)) begin
               state_d = FIX;
            end
         end
         FIX: begin
            // Magnitude is at most 2^(2DW-2), so negation never overflows.
            product_d = sign_q ? -mag : mag;
            done_d    = 1'b1;
            state_d   = DONE;
         end
         DONE: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase

      if (sync_clr) begin
         state_d   = IDLE;
         product_d = '0;
         busy_d    = 1'b0;
         done_d    = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         mcand_q   <= '0;
         mlt_q     <= '0;
         hi_q      <= '0;
         cnt_q     <= '0;
         sign_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         product_q <= '0;
      end else begin
         state_q   <= state_d;
         mcand_q   <= mcand_d;
         mlt_q     <= mlt_d;
         hi_q      <= hi_d;
         cnt_q     <= cnt_d;
         sign_q    <= sign_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         product_q <= product_d;
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign product = product_q;

endmodule

// File: tb/tb_mdr_seq_mult.sv
// tb_mdr_seq_mult -- directed self-checking bench for mdr_seq_mult.
module tb_mdr_seq_mult;

   logic        clk;
   logic        rst;
   logic        sync_clr;
   logic        start;
   logic [15:0] op_a;
   logic [15:0] op_b;
   logic        busy;
   logic        done;
   logic [31:0] product;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q[$];

   mdr_seq_mult dut (
      .clk      (clk),
      .rst      (rst),
      .sync_clr (sync_clr),
      .start    (start),
      .op_a     (op_a),
      .op_b     (op_b),
      .busy     (busy),
      .done     (done),
      .product  (product)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Drives one multiply; optionally pokes a second start at RUN sample poke_at.
   task automatic run_mult(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic [31:0] exp, input int poke_at);
      int lat;
      int nbusy;
      int ndone;
      logic [31:0] e;
      exp_q.push_back(exp);
      @(negedge clk);
      op_a  = a;
      op_b  = b;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      op_a  = 16'($urandom_range(0, 65535));
      op_b  = 16'($urandom_range(0, 65535));
      lat   = 1;
      nbusy = busy ? 1 : 0;
      ndone = done ? 1 : 0;
      while (!done && lat < 40) begin
         if (lat == poke_at) begin
            start = 1'b1;
            op_a  = 16'd9;
            op_b  = 16'd9;
         end
         @(posedge clk); #1;
         start = 1'b0;
         lat++;
         if (busy) nbusy++;
         if (done) ndone++;
      end
      e = exp_q.pop_front();
      check_eq({tag, "_latency"}, 32'(lat), 32'd18);
      check_eq({tag, "_busy_cycles"}, 32'(nbusy), 32'd18);
      check_eq({tag, "_product"}, product, e);
      @(posedge clk); #1;
      check_eq({tag, "_busy_drop"}, {31'd0, busy}, 32'd0);
      check_eq({tag, "_done_single"}, {31'd0, done}, 32'd0);
      repeat (3) begin
         @(posedge clk); #1;
         if (done) ndone++;
      end
      check_eq({tag, "_done_count"}, 32'(ndone), 32'd1);
      check_eq({tag, "_product_hold"}, product, e);
   endtask

   initial begin : main
      int ndone;
      rst      = 1'b0;
      sync_clr = 1'b0;
      start    = 1'b0;
      op_a     = '0;
      op_b     = '0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("reset_busy", {31'd0, busy}, 32'd0);
      check_eq("reset_done", {31'd0, done}, 32'd0);
      check_eq("reset_product", product, 32'd0);
      @(negedge clk);
      rst = 1'b1;

      run_mult("basic_3x5",   16'd3,      16'd5,      32'h0000_000F, 0);
      run_mult("neg7x6",      16'hFFF9,   16'd6,      32'hFFFF_FFD6, 0);
      run_mult("neg1xneg1",   16'hFFFF,   16'hFFFF,   32'h0000_0001, 0);
      run_mult("min_x_min",   16'h8000,   16'h8000,   32'h4000_0000, 0);
      run_mult("max_x_min",   16'h7FFF,   16'h8000,   32'hC000_8000, 0);
      run_mult("zero_x_max",  16'd0,      16'h7FFF,   32'h0000_0000, 0);
      run_mult("start_busy",  16'd100,    16'hFFFD,   32'hFFFF_FED4, 5);

      // sync_clr partway through RUN aborts with no done
      @(negedge clk);
      op_a  = 16'd1234;
      op_b  = 16'd567;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (7) begin
         @(posedge clk); #1;
      end
      sync_clr = 1'b1;
      @(posedge clk); #1;
      sync_clr = 1'b0;
      check_eq("clr_busy", {31'd0, busy}, 32'd0);
      check_eq("clr_product", product, 32'd0);
      check_eq("clr_done", {31'd0, done}, 32'd0);
      ndone = 0;
      repeat (25) begin
         @(posedge clk); #1;
         if (done || busy) ndone++;
      end
      check_eq("clr_no_done", 32'(ndone), 32'd0);
      run_mult("after_clr_2x2", 16'd2, 16'd2, 32'h0000_0004, 0);

      // asynchronous reset partway through RUN
      @(negedge clk);
      op_a  = 16'd300;
      op_b  = 16'hFFFE;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) begin
         @(posedge clk); #1;
      end
      #1;
      rst = 1'b0;
      #1;
      check_eq("arst_busy", {31'd0, busy}, 32'd0);
      check_eq("arst_done", {31'd0, done}, 32'd0);
      check_eq("arst_product", product, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      ndone = 0;
      repeat (25) begin
         @(posedge clk); #1;
         if (done || busy) ndone++;
      end
      check_eq("arst_no_done", 32'(ndone), 32'd0);
      run_mult("after_arst", 16'hFED4, 16'd2, 32'hFFFF_FDA8, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
